// File: rtl/seq_detect_ctrl_if.sv
// Host/stream-side signal bundle for seq_detect_ctrl.
// Driver side uses the master modport. The detector uses the slave modport.
interface seq_detect_ctrl_if #(
    parameter int unsigned SYM_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic [SYM_W-1:0] cfg_sym;
    logic             cfg_last;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] hit_target;
    logic             data_valid;
    logic [SYM_W-1:0] data;
    logic             sequence_found;
    logic [CNT_W-1:0] hit_count;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_sym, cfg_last, start, abort, hit_target, data_valid, data,
        input  sequence_found, hit_count, busy, done, timeout, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_sym, cfg_last, start, abort, hit_target, data_valid, data,
        output sequence_found, hit_count, busy, done, timeout, cfg_err
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable symbol-sequence detector with a load/arm/done control FSM.
// Defining SEQ_CTRL_NO_OVERLAP_EN makes each match consume its symbols, so matches cannot overlap.
module seq_detect_ctrl #(
    parameter int unsigned SYM_W       = 3,
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input logic         clk,
    input logic         reset_n,
    seq_detect_ctrl_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned IDL_W = $clog2(TIMEOUT_CYC + 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED, S_DONE} state_t;
    typedef logic [MAX_LEN-1:0][SYM_W-1:0] symvec_t;

    localparam symvec_t DFLT_PATTERN =
        symvec_t'({3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001});
    localparam logic [LEN_W-1:0] DFLT_LEN = LEN_W'(7);

    state_t           state_q, state_d;
    symvec_t          pattern_q, pattern_d;
    symvec_t          stage_q, stage_d;
    symvec_t          hist_q, hist_d, hist_new;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wptr_q, wptr_d;
    logic [LEN_W-1:0] vcnt_q, vcnt_d, vcnt_new;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [IDL_W-1:0] idle_q, idle_d;
    logic             match_q, match_d;
    logic             found_q, found_d;
    logic             timeout_q, timeout_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match_now;

    // Compare the window that would exist once the incoming symbol is shifted in.
    always_comb begin
        hist_new  = {hist_q[MAX_LEN-2:0], bus.data};
        vcnt_new  = (vcnt_q == LEN_W'(MAX_LEN)) ? vcnt_q : vcnt_q + 1'b1;
        match_now = (len_q != '0) && (vcnt_new >= len_q);
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if ((LEN_W'(k) < len_q) &&
                (hist_new[IDX_W'(k)] != pattern_q[IDX_W'(len_q - LEN_W'(k) - 1'b1)])) begin
                match_now = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        stage_d   = stage_q;
        hist_d    = hist_q;
        len_d     = len_q;
        wptr_d    = wptr_q;
        vcnt_d    = vcnt_q;
        hit_d     = hit_q;
        target_d  = target_q;
        idle_d    = idle_q;
        match_d   = 1'b0;
        found_d   = 1'b0;
        timeout_d = timeout_q;
        cfg_err_d = cfg_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.cfg_valid) begin
                    stage_d[0] = bus.cfg_sym;
                    wptr_d     = LEN_W'(1);
                    if (bus.cfg_last) begin
                        pattern_d[0] = bus.cfg_sym;
                        len_d        = LEN_W'(1);
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (bus.start) begin
                    if (len_q == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d   = S_ARMED;
                        hist_d    = '0;
                        vcnt_d    = '0;
                        hit_d     = '0;
                        timeout_d = 1'b0;
                        idle_d    = '0;
                        target_d  = bus.hit_target;
                    end
                end
            end

            // New symbols go to a staging copy so an aborted load leaves the live pattern intact.
            S_LOAD: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.cfg_valid) begin
                    if (wptr_q == LEN_W'(MAX_LEN)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        stage_d[IDX_W'(wptr_q)] = bus.cfg_sym;
                        wptr_d                  = wptr_q + 1'b1;
                    end
                    if (bus.cfg_last) begin
                        pattern_d = stage_d;
                        len_d     = (wptr_q == LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : wptr_q + 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_ARMED: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (match_q) begin
                        hit_d   = (hit_q == '1) ? hit_q : hit_q + 1'b1;
                        found_d = 1'b1;
                    end
                    if (bus.data_valid) begin
                        hist_d  = hist_new;
                        idle_d  = '0;
                        match_d = match_now;
`ifdef SEQ_CTRL_NO_OVERLAP_EN
                        vcnt_d  = match_now ? '0 : vcnt_new;
`else
                        vcnt_d  = vcnt_new;
`endif
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                    if (match_q && (target_q != '0) && (hit_d == target_q)) begin
                        state_d = S_DONE;
                        match_d = 1'b0;
                    end else if ((TIMEOUT_CYC != 0) && !bus.data_valid &&
                                 (idle_d == IDL_W'(TIMEOUT_CYC))) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        match_d   = 1'b0;
                    end
                end
            end

            S_DONE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.start && (len_q != '0)) begin
                    state_d   = S_ARMED;
                    hist_d    = '0;
                    vcnt_d    = '0;
                    hit_d     = '0;
                    timeout_d = 1'b0;
                    idle_d    = '0;
                    target_d  = bus.hit_target;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_ARMED);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pattern_q <= DFLT_PATTERN;
            stage_q   <= '0;
            hist_q    <= '0;
            len_q     <= DFLT_LEN;
            wptr_q    <= '0;
            vcnt_q    <= '0;
            hit_q     <= '0;
            target_q  <= '0;
            idle_q    <= '0;
            match_q   <= 1'b0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            stage_q   <= stage_d;
            hist_q    <= hist_d;
            len_q     <= len_d;
            wptr_q    <= wptr_d;
            vcnt_q    <= vcnt_d;
            hit_q     <= hit_d;
            target_q  <= target_d;
            idle_q    <= idle_d;
            match_q   <= match_d;
            found_q   <= found_d;
            timeout_q <= timeout_d;
            cfg_err_q <= cfg_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sequence_found = found_q;
    assign bus.hit_count      = hit_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.timeout        = timeout_q;
    assign bus.cfg_err        = cfg_err_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus queues expected pulses, a monitor checks them.
// Expected overlap result follows SEQ_CTRL_NO_OVERLAP_EN.
module tb_seq_detect_ctrl;
    localparam int unsigned SYM_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_ctrl_if #(.SYM_W(SYM_W), .CNT_W(CNT_W)) bus ();

    seq_detect_ctrl #(
        .SYM_W(SYM_W),
        .MAX_LEN(8),
        .CNT_W(CNT_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the queue in cycle and count.
    always @(negedge clk) begin
        exp_t e;
        if (bus.sequence_found) begin
            if (sbq.size() == 0) begin
                check("spurious_pulse", 0, 1);
            end else begin
                e = sbq.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_hit_count", int'(bus.hit_count), e.cnt);
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            check("missed_pulse", int'(bus.sequence_found), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SYM_W-1:0] sym, input int exp_cnt);
        bus.data_valid = 1'b1;
        bus.data       = sym;
        tick();
        if (exp_cnt >= 0) sbq.push_back('{cyc + 1, exp_cnt});
        bus.data_valid = 1'b0;
    endtask

    task automatic cfg(input logic [SYM_W-1:0] sym, input logic last);
        bus.cfg_valid = 1'b1;
        bus.cfg_sym   = sym;
        bus.cfg_last  = last;
        tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] tgt);
        bus.start      = 1'b1;
        bus.hit_target = tgt;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic default_stream();
        send(3'b001, -1);
        send(3'b101, -1);
        send(3'b110, -1);
        send(3'b000, -1);
        send(3'b110, -1);
        send(3'b110, -1);
        send(3'b011, 1);
        send(3'b101, -1);
        tick();
        tick();
    endtask

    initial begin
        int ov_exp;
        logic [SYM_W-1:0] ovf_syms [10];
        bus.cfg_valid  = 1'b0;
        bus.cfg_sym    = '0;
        bus.cfg_last   = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.hit_target = '0;
        bus.data_valid = 1'b0;
        bus.data       = '0;

        // Reset values
        tick();
        tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        check("rst_hit_count", int'(bus.hit_count), 0);
        check("rst_found", int'(bus.sequence_found), 0);
        reset_n = 1'b1;
        tick();

        // Default pattern
        do_start(8'd0);
        check("dflt_armed_busy", int'(bus.busy), 1);
        default_stream();
        check("dflt_hit_count", int'(bus.hit_count), 1);
        check("dflt_busy", int'(bus.busy), 1);
        check("dflt_done", int'(bus.done), 0);
        do_abort();
        check("dflt_abort_busy", int'(bus.busy), 0);

        // Reprogram to 111,010
        cfg(3'b111, 1'b0);
        check("load_busy", int'(bus.busy), 1);
        cfg(3'b010, 1'b1);
        check("load_end_busy", int'(bus.busy), 0);
        do_start(8'd0);
        send(3'b111, -1);
        send(3'b010, 1);
        send(3'b111, -1);
        send(3'b010, 2);
        tick();
        tick();
        check("reprog_hit_count", int'(bus.hit_count), 2);
        do_abort();

        // Hit target = 3 on single-symbol pattern 101
        cfg(3'b101, 1'b1);
        check("len1_stays_idle", int'(bus.busy), 0);
        do_start(8'd3);
        send(3'b101, 1);
        send(3'b101, 2);
        send(3'b101, 3);
        send(3'b101, -1);
        check("tgt_done_edge", int'(bus.done), 1);
        send(3'b101, -1);
        tick();
        check("tgt_done", int'(bus.done), 1);
        check("tgt_hit_count", int'(bus.hit_count), 3);
        check("tgt_busy", int'(bus.busy), 0);
        do_start(8'd0);
        check("rearm_hit_count", int'(bus.hit_count), 0);
        check("rearm_busy", int'(bus.busy), 1);
        check("rearm_done", int'(bus.done), 0);
        do_abort();

        // Idle timeout, then timeout delayed by a symbol at cycle 10
        do_start(8'd0);
        repeat (15) tick();
        check("to_not_yet", int'(bus.done), 0);
        tick();
        check("to_done", int'(bus.done), 1);
        check("to_flag", int'(bus.timeout), 1);
        check("to_hit_count", int'(bus.hit_count), 0);
        do_start(8'd0);
        check("to_rearm_flag", int'(bus.timeout), 0);
        repeat (9) tick();
        send(3'b000, -1);
        repeat (15) tick();
        check("to2_not_yet", int'(bus.done), 0);
        tick();
        check("to2_done", int'(bus.done), 1);
        check("to2_flag", int'(bus.timeout), 1);
        do_abort();

        // Overflow: 10 writes, only the first 8 kept
        ovf_syms = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd6, 3'd6};
        for (int i = 0; i < 10; i++) cfg(ovf_syms[i], (i == 9) ? 1'b1 : 1'b0);
        check("ovf_cfg_err", int'(bus.cfg_err), 1);
        check("ovf_idle", int'(bus.busy), 0);
        do_start(8'd0);
        for (int i = 0; i < 7; i++) send(ovf_syms[i], -1);
        send(ovf_syms[7], 1);
        tick();
        tick();
        check("ovf_len8_hits", int'(bus.hit_count), 1);
        do_abort();
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("cfg_err_sticky", int'(bus.cfg_err), 1);

        // Reset mid-run restores defaults
        do_start(8'd0);
        send(3'b001, -1);
        reset_n = 1'b0;
        tick();
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_cfg_err", int'(bus.cfg_err), 0);
        check("midrst_hit_count", int'(bus.hit_count), 0);
        reset_n = 1'b1;
        tick();
        do_start(8'd0);
        default_stream();
        check("midrst_dflt_hits", int'(bus.hit_count), 1);
        do_abort();

        // Overlap
`ifdef SEQ_CTRL_NO_OVERLAP_EN
        ov_exp = 1;
`else
        ov_exp = 2;
`endif
        cfg(3'b000, 1'b0);
        cfg(3'b000, 1'b1);
        do_start(8'd0);
        send(3'b000, -1);
        send(3'b000, 1);
        send(3'b000, (ov_exp == 2) ? 2 : -1);
        tick();
        tick();
        check("overlap_hits", int'(bus.hit_count), ov_exp);
        do_abort();

        // Aborted load keeps the previous pattern
        cfg(3'b111, 1'b0);
        do_abort();
        check("load_abort_busy", int'(bus.busy), 0);
        do_start(8'd0);
        send(3'b000, -1);
        send(3'b000, 1);
        tick();
        tick();
        check("load_abort_pattern", int'(bus.hit_count), 1);
        do_abort();
        tick();

        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable 3-bit-symbol sequence detector with a control FSM. It loads a match pattern, arms and disarms detection, counts hits, and terminates a run on a hit target, on an idle timeout, or on abort. It sits between the host/config side and the symbol stream, and replaces the fixed-pattern detector at the same datapath position.

Parameters:
SYM_W, 3, symbol width in bits
MAX_LEN, 8, pattern depth in symbols (also the history depth)
CNT_W, 8, width of the hit counter and hit target
TIMEOUT_CYC, 1023, idle cycles (no accepted symbol) while ARMED before timeout; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous, active-low reset
cfg_valid  in  1  pattern symbol write strobe
cfg_sym  in  SYM_W  pattern symbol
cfg_last  in  1  with cfg_valid: marks the final pattern symbol
start  in  1  arm, or re-arm from DONE
abort  in  1  return to IDLE
hit_target  in  CNT_W  hits that end the run; 0 = unlimited; sampled at start
data_valid  in  1  data qualifier
data  in  SYM_W  input symbol
sequence_found  out  1  one-cycle pulse per match
hit_count  out  CNT_W  matches in the current run
busy  out  1  high in LOAD or ARMED
done  out  1  high in DONE
timeout  out  1  DONE was reached by timeout
cfg_err  out  1  sticky: pattern overflow or empty-pattern start

Behaviour:
- Reset (reset_n low at posedge) loads the following values.
  - State = IDLE; all outputs = 0.
  - Pattern length = 7; pattern = 001,101,110,000,110,110,011 (index 0 first).
  - History cleared; hit counter and idle counter = 0.
- States: IDLE, LOAD, ARMED, DONE.
- Priority within a cycle: reset > abort > cfg/start > data.
- IDLE:
  - cfg_valid writes pattern[0], sets wptr = 1, and enters LOAD. If cfg_last is also high, length = 1 and the state stays IDLE.
  - start with length >= 1 enters ARMED, clears history, hit_count, timeout and idle counter, and latches hit_target.
  - start with length 0 is not possible after reset.
- LOAD:
  - cfg_valid writes pattern[wptr] and increments wptr.
  - cfg_valid with cfg_last sets length = wptr + 1 and returns to IDLE.
  - A write with wptr = MAX_LEN is dropped and sets cfg_err. On cfg_last after overflow, length = MAX_LEN.
  - start is ignored in LOAD.
  - abort returns to IDLE and keeps the previous pattern and length.
- ARMED:
  - Each data_valid shifts data into history; symbol valid-count saturates at MAX_LEN.
  - Match when valid-count (including the new symbol) >= length and the last `length` symbols equal pattern[0..length-1] in order.
  - Match → next cycle sequence_found = 1 for one cycle and hit_count + 1, saturating at all-ones.
  - Overlapping matches are counted.
  - Latency: symbol sampled at edge N → pulse visible N+1 to N+2.
  - Run ends when hit_count reaches a non-zero target: DONE on the same edge the final hit registers.
  - Idle counter: cleared by data_valid, otherwise +1. Reaching TIMEOUT_CYC enters DONE with timeout = 1.
  - data_valid low: history is held.
  - cfg_valid in ARMED is ignored.
- DONE:
  - done = 1; hit_count and timeout hold.
  - start re-arms as from IDLE; abort → IDLE.
  - Data is ignored.
- cfg_err clears only on reset.
- Reset mid-run: immediate IDLE and the default pattern is restored.

Optional Feature:
Macro SEQ_CTRL_NO_OVERLAP_EN.
- Defined: after each match, history valid-count clears, so the next match needs `length` fresh symbols. Example: pattern 00,00 on input 00,00,00 gives 1 hit.
- Undefined: overlapping matches are counted. The same example gives 2 hits.

Test Plan:
- Default pattern:
  - Stimulus: reset, start with hit_target = 0, then symbols 001,101,110,000,110,110,011,101.
  - Response: single sequence_found pulse following the 011 symbol; hit_count = 1; busy = 1; done = 0.
- Reprogram:
  - Stimulus: load 111,010 (cfg_last on the second), start, stream 111,010,111,010.
  - Response: 2 pulses; hit_count = 2.
- Hit target:
  - Stimulus: pattern 101, hit_target = 3, stream 101 five times.
  - Response: done = 1 after the third hit; hit_count = 3; pulses 4–5 are absent; a further start re-arms with hit_count = 0.
- Timeout:
  - Stimulus: TIMEOUT_CYC = 16, arm, no data_valid for 16 cycles.
  - Response: done = 1, timeout = 1, hit_count = 0.
  - Also: one data_valid at cycle 10 delays timeout to cycle 26.
- Overflow/abort:
  - Stimulus: write 10 symbols with cfg_last on the 10th.
  - Response: cfg_err = 1 and length = 8.
  - Stimulus: abort mid-ARMED.
  - Response: IDLE; busy = 0 next cycle; reset clears cfg_err.
- Overlap:
  - Stimulus: pattern 000,000, stream 000 ×3.
  - Response: hit_count = 2 with the macro undefined, 1 with it defined.
